// File: rtl/fir_requant_pkg.sv
// Shared constants for the FIR-to-DAC requantization stage: per-bank shifts,
// DAC code limits and the error-bit encoding.
package fir_requant_pkg;

  localparam int SHIFT_W = 5;

  // Shift applied to the 35-bit FIR result for each filter bank.
  localparam logic [SHIFT_W-1:0] BANK_SHIFT [4] = '{5'd20, 5'd21, 5'd22, 5'd23};

  localparam logic [11:0] MIDSCALE = 12'h800;

  localparam logic [1:0] ERR_SAT      = 2'b10;
  localparam logic [1:0] ERR_UPSTREAM = 2'b01;

  localparam int DAC_MIN = -2048;
  localparam int DAC_MAX = 2047;

endpackage

// File: rtl/fir_requant_stage_if.sv
// Avalon-ST style sample stream: data, a one-cycle valid strobe and a 2-bit error.
// Handshake: a beat transfers on every cycle valid is high; there is no ready,
// so the consumer must take one beat per clock.
interface fir_requant_stage_if #(
  parameter int DATA_W = 35
);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic [1:0]        error;

  modport master (output data, output valid, output error);
  modport slave  (input  data, input  valid, input  error);
endinterface

// File: rtl/round_sat_shift.sv
// Combinational round-half-up arithmetic right shift, clamped to the DAC range
// and converted to offset-binary.
module round_sat_shift
  import fir_requant_pkg::*;
#(
  parameter int DATA_IN_W  = 35,
  parameter int DATA_OUT_W = 12
) (
  input  logic [DATA_IN_W-1:0]  x,
  input  logic [SHIFT_W-1:0]    shift,
  output logic [DATA_OUT_W-1:0] code,
  output logic                  saturated
);
  localparam int ACC_W = DATA_IN_W + 1;

  logic signed [ACC_W-1:0]  x_ext;
  logic signed [ACC_W-1:0]  rnd;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  y;
  logic        [DATA_OUT_W-1:0] y_c;
  logic                     over;
  logic                     under;

  always_comb begin
    // One extra bit of headroom keeps x + 2^(s-1) from wrapping at full scale.
    x_ext = ACC_W'($signed(x));
    rnd   = ACC_W'(1) << (shift - 5'd1);
    sum   = x_ext + rnd;
    y     = sum >>> shift;
    over  = (y > ACC_W'(DAC_MAX));
    under = (y < ACC_W'(DAC_MIN));
    if (over) begin
      y_c = DATA_OUT_W'(DAC_MAX);
    end else if (under) begin
      y_c = DATA_OUT_W'(DAC_MIN);
    end else begin
      y_c = y[DATA_OUT_W-1:0];
    end
    saturated = over | under;
    code      = {~y_c[DATA_OUT_W-1], y_c[DATA_OUT_W-2:0]};
  end

endmodule

// File: rtl/fir_requant_stage.sv
// Two-stage requantizer: FIR result -> 12-bit offset-binary DAC code with
// bank-dependent scaling, mute-on-bank-change and a clipped-sample counter.
module fir_requant_stage
  import fir_requant_pkg::*;
#(
  parameter int DATA_IN_W    = 35,
  parameter int DATA_OUT_W   = 12,
  parameter int MUTE_SAMPLES = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          sel,
  fir_requant_stage_if.slave  ast_sink,
  fir_requant_stage_if.master ast_source,
  output logic [7:0]          sat_count,
  output logic                muted
);

  logic                  accept;
  logic                  bank_change;
  logic [1:0]            last_sel;
  logic [7:0]            mute_cnt;

  logic                  s1_valid;
  logic                  s1_mute;
  logic                  s1_err;
  logic [DATA_IN_W-1:0]  s1_x;
  logic [SHIFT_W-1:0]    s1_shift;

  logic [DATA_OUT_W-1:0] rs_code;
  logic                  rs_sat;
  logic                  sat_event;

  assign accept      = ast_sink.valid;
  assign bank_change = accept && (sel != last_sel);
  assign muted       = (mute_cnt != 8'd0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_mute  <= 1'b0;
      s1_err   <= 1'b0;
      s1_x     <= '0;
      s1_shift <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_x     <= ast_sink.data;
        s1_shift <= BANK_SHIFT[sel];
        s1_err   <= (ast_sink.error != 2'b00);
        s1_mute  <= bank_change || muted;
      end
    end
  end

  // A bank change mutes the sample that carries it, so the reload already
  // accounts for that one.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mute_cnt <= 8'(MUTE_SAMPLES);
      last_sel <= 2'd0;
    end else if (accept) begin
      last_sel <= sel;
      if (bank_change) begin
        mute_cnt <= 8'(MUTE_SAMPLES - 1);
      end else if (muted) begin
        mute_cnt <= mute_cnt - 8'd1;
      end
    end
  end

  round_sat_shift #(
    .DATA_IN_W  (DATA_IN_W),
    .DATA_OUT_W (DATA_OUT_W)
  ) u_round_sat_shift (
    .x         (s1_x),
    .shift     (s1_shift),
    .code      (rs_code),
    .saturated (rs_sat)
  );

  assign sat_event = s1_valid && rs_sat && !s1_mute && !s1_err;

  // The clear comes from the newer sample, so it wins over an older clip.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sat_count <= 8'd0;
    end else if (bank_change) begin
      sat_count <= 8'd0;
    end else if (sat_event && (sat_count != 8'hFF)) begin
      sat_count <= sat_count + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ast_source.valid <= 1'b0;
      ast_source.data  <= MIDSCALE;
      ast_source.error <= 2'b00;
    end else begin
      ast_source.valid <= s1_valid;
      if (s1_valid) begin
        ast_source.data  <= (s1_mute || s1_err) ? MIDSCALE : rs_code;
        ast_source.error <= (sat_event ? ERR_SAT : 2'b00) | (s1_err ? ERR_UPSTREAM : 2'b00);
      end
    end
  end

endmodule

// File: tb/tb_fir_requant_stage.sv
// Bench for fir_requant_stage: directed and random samples against an
// arithmetic reference model, outputs checked from an expected queue.
module tb_fir_requant_stage;

  localparam int MUTE = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] sel = 2'd0;
  logic [7:0] sat_count;
  logic       muted;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int m_cnt = MUTE;
  int m_last = 0;
  int m_sat = 0;
  int shift_tab [4] = '{20, 21, 22, 23};

  logic [13:0] exp_q [$];
  int          cyc_q [$];

  fir_requant_stage_if #(.DATA_W(35)) sink_if ();
  fir_requant_stage_if #(.DATA_W(12)) source_if ();

  fir_requant_stage #(
    .DATA_IN_W    (35),
    .DATA_OUT_W   (12),
    .MUTE_SAMPLES (MUTE)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sel        (sel),
    .ast_sink   (sink_if),
    .ast_source (source_if),
    .sat_count  (sat_count),
    .muted      (muted)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void ref_code(input logic [34:0] x, input int s,
                                   output logic [11:0] code, output bit sat);
    longint xv, d, num, y;
    xv  = longint'($signed(x));
    d   = 64'sd1 << s;
    num = xv + d / 2;
    y   = num / d;
    if ((num % d != 0) && (num < 0)) y = y - 1;
    sat = (y > 2047) || (y < -2048);
    if (y > 2047)  y = 2047;
    if (y < -2048) y = -2048;
    code = 12'(y + 2048);
  endfunction

  task automatic model_accept(input logic [34:0] x, input logic [1:0] s,
                              input logic [1:0] e, input int c);
    logic [11:0] code;
    bit          sat;
    bit          mute_now;
    if (int'(s) != m_last) begin
      m_cnt  = MUTE;
      m_sat  = 0;
      m_last = int'(s);
    end
    mute_now = (m_cnt != 0);
    if (m_cnt != 0) m_cnt--;
    ref_code(x, shift_tab[s], code, sat);
    if (e != 2'b00)    exp_q.push_back({2'b01, 12'h800});
    else if (mute_now) exp_q.push_back({2'b00, 12'h800});
    else if (sat) begin
      exp_q.push_back({2'b10, code});
      if (m_sat < 255) m_sat++;
    end else           exp_q.push_back({2'b00, code});
    cyc_q.push_back(c);
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [34:0] x, input logic [1:0] s, input logic [1:0] e);
    int c;
    @(negedge clk);
    sel           = s;
    sink_if.data  = x;
    sink_if.error = e;
    sink_if.valid = 1'b1;
    c = cyc;
    @(posedge clk);
    model_accept(x, s, e, c);
    #1;
    check("muted", 32'(muted), 32'(m_cnt != 0));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sink_if.valid = 1'b0;
      sink_if.error = 2'b00;
    end
  endtask

  task automatic idle_sel(input int n, input logic [1:0] s);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sink_if.valid = 1'b0;
      sel = s;
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    #2;
    reset_n       = 1'b0;
    sink_if.valid = 1'b0;
    sink_if.error = 2'b00;
    exp_q.delete();
    cyc_q.delete();
    m_cnt  = MUTE;
    m_last = 0;
    m_sat  = 0;
    repeat (n) @(posedge clk);
    #1;
    check("rst_valid", 32'(source_if.valid), 32'd0);
    check("rst_data", 32'(source_if.data), 32'h800);
    check("rst_error", 32'(source_if.error), 32'd0);
    check("rst_sat_count", 32'(sat_count), 32'd0);
    check("rst_muted", 32'(muted), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic drain_check_sat(input string name);
    idle(4);
    check(name, 32'(sat_count), 32'(m_sat));
  endtask

  function automatic logic [34:0] rand_x();
    logic signed [34:0] v;
    v = 35'({$urandom, $urandom});
    case ($urandom_range(0, 7))
      0:       v = 35'h3_FFFF_FFFF;
      1:       v = 35'h4_0000_0000;
      default: v = v >>> $urandom_range(0, 14);
    endcase
    return v;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [13:0] e;
    int          c;
    if (source_if.valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stray_valid actual=valid required=no_valid data=%0h t=%0t",
                 source_if.data, $time);
      end else begin
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        check("out_data", 32'(source_if.data), 32'(e[11:0]));
        check("out_error", 32'(source_if.error), 32'(e[13:12]));
        check("out_latency", 32'(cyc), 32'(c + 2));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] rs;
    logic [1:0] re;
    sink_if.data  = '0;
    sink_if.valid = 1'b0;
    sink_if.error = 2'b00;

    do_reset(3);

    // mute after reset: 16 muted samples, 17th passes through
    for (int i = 0; i < 17; i++) send(35'h0_0010_0000, 2'd0, 2'b00);
    idle(3);

    // rounding and sign handling
    send(35'h0_0008_0000, 2'd0, 2'b00);
    idle(2);
    send(-35'sh0_0008_0000, 2'd0, 2'b00);
    send(-35'sh0_0010_0000, 2'd0, 2'b00);
    idle(3);

    // saturation both ways and full-scale positive
    send(35'h1_0000_0000, 2'd0, 2'b00);
    send(-35'sh1_0000_0000, 2'd0, 2'b00);
    send(35'h3_FFFF_FFFF, 2'd0, 2'b00);
    drain_check_sat("sat_count_three");
    check("sat_count_const", 32'(sat_count), 32'd3);

    // bank switch 0 -> 3 clears the clip count and restarts the mute
    send(35'h1_0000_0000, 2'd3, 2'b00);
    check("sat_count_clear", 32'(sat_count), 32'd0);
    for (int i = 0; i < 15; i++) send(35'h1_0000_0000, 2'd3, 2'b00);
    send(35'h0_0080_0000, 2'd3, 2'b00);
    idle(3);

    // sel wiggle with no valid must not count as a bank change
    idle_sel(3, 2'd2);
    send(35'h3_FFFF_FFFF, 2'd3, 2'b00);
    drain_check_sat("sat_count_one");

    // upstream error leaves the clip count alone
    send(35'h1_0000_0000, 2'd3, 2'b01);
    drain_check_sat("sat_count_err_hold");

    // back-to-back random stream
    for (int i = 0; i < 40; i++) begin
      rs = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : sel;
      re = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      send(rand_x(), rs, re);
    end
    drain_check_sat("sat_count_random");

    // reset mid-stream: in-flight samples vanish and the mute restarts
    for (int i = 0; i < 5; i++) send(rand_x(), 2'd1, 2'b00);
    do_reset(2);
    idle(5);
    for (int i = 0; i < 17; i++) send(35'h0_0010_0000, 2'd0, 2'b00);

    // random stream with gaps
    for (int i = 0; i < 30; i++) begin
      rs = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : sel;
      re = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      send(rand_x(), rs, re);
      idle($urandom_range(0, 2));
    end
    drain_check_sat("sat_count_final");

    idle(4);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
